top_broadcast_transmitter: RTL

TOP_BROADCAST_TRANSMITTER -- requirements
Module: top_broadcast_transmitter

---
 rtl/top_broadcast_transmitter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/top_broadcast_transmitter.sv
// Serialises top into LANES-bit beats (LSB chunk first) and broadcasts them to N_DEST channels.
// Define TOP_BROADCAST_PARITY_EN to append an XOR parity beat to every transfer.
module top_broadcast_transmitter #(
    parameter int unsigned TOP_WIDTH     = 128,
    parameter int unsigned LANES         = 2,
    parameter int unsigned N_DEST        = 4,
    parameter int unsigned FANOUT_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [TOP_WIDTH-1:0]           top,
    input  logic                           transmitTop,
    output logic                           busy,
    output logic                           doneTransmitting,
    output logic [N_DEST*(LANES+1)-1:0]    topChannel
);
    localparam int unsigned Chunks     = TOP_WIDTH / LANES;
    localparam int unsigned CountWidth = $clog2(Chunks + 1);
    localparam int unsigned FrameWidth = LANES + 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(Chunks - 1);

    typedef enum logic [1:0] {
        StIdle,
`ifdef TOP_BROADCAST_PARITY_EN
        StParity,
`endif
        StSend
    } state_t;

    state_t                  state;
    logic [TOP_WIDTH-1:0]    shiftReg;
    logic [TOP_WIDTH-1:0]    shadowTop;
    logic                    pending;
    logic [CountWidth-1:0]   beatCount;
    logic [FrameWidth-1:0]   coreFrame;
    logic                    coreLast;
`ifdef TOP_BROADCAST_PARITY_EN
    logic [LANES-1:0]        parityAcc;
`endif

    // A request on the completing edge beats the older shadow value.
    logic                    restart;
    logic [TOP_WIDTH-1:0]    nextTop;
    assign restart = transmitTop || pending;
    assign nextTop = transmitTop ? top : shadowTop;

    assign busy = (state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            shiftReg  <= '0;
            shadowTop <= '0;
            pending   <= 1'b0;
            beatCount <= '0;
            coreFrame <= '0;
            coreLast  <= 1'b0;
`ifdef TOP_BROADCAST_PARITY_EN
            parityAcc <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    coreFrame <= '0;
                    coreLast  <= 1'b0;
                    if (transmitTop) begin
                        shiftReg  <= top;
                        beatCount <= '0;
`ifdef TOP_BROADCAST_PARITY_EN
                        parityAcc <= '0;
`endif
                        state     <= StSend;
                    end
                end
                StSend: begin
                    coreFrame <= {1'b1, shiftReg[LANES-1:0]};
                    shiftReg  <= shiftReg >> LANES;
                    beatCount <= beatCount + 1'b1;
`ifdef TOP_BROADCAST_PARITY_EN
                    parityAcc <= parityAcc ^ shiftReg[LANES-1:0];
                    coreLast  <= 1'b0;
                    if (transmitTop) begin
                        shadowTop <= top;
                        pending   <= 1'b1;
                    end
                    if (beatCount == LastCount) begin
                        state <= StParity;
                    end
`else
                    if (beatCount == LastCount) begin
                        coreLast <= 1'b1;
                        if (restart) begin
                            shiftReg  <= nextTop;
                            beatCount <= '0;
                            pending   <= 1'b0;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        coreLast <= 1'b0;
                        if (transmitTop) begin
                            shadowTop <= top;
                            pending   <= 1'b1;
                        end
                    end
`endif
                end
`ifdef TOP_BROADCAST_PARITY_EN
                StParity: begin
                    coreFrame <= {1'b1, parityAcc};
                    coreLast  <= 1'b1;
                    if (restart) begin
                        shiftReg  <= nextTop;
                        beatCount <= '0;
                        parityAcc <= '0;
                        pending   <= 1'b0;
                        state     <= StSend;
                    end else begin
                        state <= StIdle;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

    if (FANOUT_STAGES == 0) begin : gDirect
        assign doneTransmitting = coreLast;
        for (genvar d = 0; d < N_DEST; d++) begin : gDest
            assign topChannel[d*FrameWidth +: FrameWidth] = coreFrame;
        end
    end else begin : gFanout
        localparam int unsigned PipeWidth = FANOUT_STAGES * FrameWidth;

        logic [FANOUT_STAGES-1:0] donePipe;
        always_ff @(posedge clk) begin
            if (rst) donePipe <= '0;
            else     donePipe <= (donePipe << 1) | FANOUT_STAGES'(coreLast);
        end
        assign doneTransmitting = donePipe[FANOUT_STAGES-1];

        // Each destination owns its own register chain so fanout load stays local.
        for (genvar d = 0; d < N_DEST; d++) begin : gDest
            logic [PipeWidth-1:0] pipe;
            always_ff @(posedge clk) begin
                if (rst) pipe <= '0;
                else     pipe <= (pipe << FrameWidth) | PipeWidth'(coreFrame);
            end
            assign topChannel[d*FrameWidth +: FrameWidth] = pipe[PipeWidth-1 -: FrameWidth];
        end
    end

endmodule
